// File: rtl/zifi_rx_fifo_pkg.sv
// Shared ZiFi FIFO constants: default depth, hold margin and status bit
// positions used by the port decoder and both FIFOs.
package zifi_rx_fifo_pkg;

  // Default FIFO depth as log2 (256 bytes).
  localparam int unsigned ZIFI_FIFO_DEPTH_LOG2 = 8;

  // Hold is raised when this many or fewer slots remain free.
  localparam int unsigned ZIFI_HOLD_MARGIN = 16;

  // Bit positions of the FIFO status flags in the CPU status register.
  typedef enum int unsigned {
    ZIFI_ST_EMPTY    = 0,
    ZIFI_ST_FULL     = 1,
    ZIFI_ST_OVERFLOW = 2,
    ZIFI_ST_HOLD     = 3
  } zifi_status_bit_e;

  // Number of entries for a given log2 depth.
  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/zifi_fifo_mem.sv
// FIFO storage: 2**DEPTH_LOG2 x 8 array, synchronous write, asynchronous
// read. Contents are deliberately not reset.
module zifi_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_bus,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [7:0] mem [DEPTH];

  // Write port: store the byte at the write pointer when enabled.
  always_ff @(posedge clk_bus) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: head byte is visible without a clock edge.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/zifi_rx_fifo.sv
// Receive-side byte buffer between uart_rx and the ZiFi CPU port registers.
// Accepts every byte uart_rx reports, acknowledges it on the next cycle,
// and holds it until the CPU pops it. Tracks fill level, sticky overflow
// and a registered near-full hold flag for remote flow control.
module zifi_rx_fifo
  import zifi_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = ZIFI_FIFO_DEPTH_LOG2,
  parameter int unsigned HOLD_MARGIN = ZIFI_HOLD_MARGIN
) (
  input  logic                clk_bus,
  input  logic                rst_n,
  input  logic [7:0]          rxdata,
  input  logic                rxrecv,
  output logic                data_read,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  input  logic                clr,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                hold
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_LOG2);
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_MARGIN = CNT_W'(HOLD_MARGIN);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [CNT_W-1:0]      free_nxt;
  logic                  overflow_nxt;
  logic                  hold_nxt;
  logic                  release_done;

  logic                  do_pop;
  logic                  do_push;
  logic                  do_drop;

  // Status flags derived directly from the stored count.
  always_comb begin
    empty = (count == CNT_ZERO);
    full  = (count == CNT_FULL);
  end

  // Transfer qualification. clr overrides everything; a full FIFO still
  // accepts a byte when the same cycle frees a slot by popping.
  always_comb begin
    do_pop  = rd_en & ~empty & ~clr;
    do_push = rxrecv & ~clr & (~full | do_pop);
    do_drop = rxrecv & ~clr & ~do_push;
  end

  // Next-state pointers, count, overflow and hold.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    overflow_nxt = overflow;
    if (clr) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_nxt = rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
      if (do_drop) begin
        overflow_nxt = 1'b1;
      end
    end
    free_nxt = CNT_FULL - count_nxt;
    hold_nxt = (free_nxt <= CNT_MARGIN);
  end

  // State registers. data_read acknowledges every rxrecv one cycle later;
  // release_done forces one extra pulse on the first edge after reset so a
  // uart_rx parked in WAIT (it has no reset) is freed.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      hold         <= 1'b0;
      data_read    <= 1'b0;
      release_done <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      overflow     <= overflow_nxt;
      hold         <= hold_nxt;
      data_read    <= rxrecv | ~release_done;
      release_done <= 1'b1;
    end
  end

  zifi_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_bus (clk_bus),
    .we      (do_push),
    .waddr   (wr_ptr),
    .wdata   (rxdata),
    .raddr   (rd_ptr),
    .rdata   (rd_data)
  );

endmodule
